// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Package     : riscv_pkg
// Description : Shared RV32M encodings for the risc5 core. Holds the funct3
//               op codes of the M extension (also used by the decoder) and
//               the state encoding of the iterative multiply/divide unit.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

  // RV32M funct3 op codes
  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  // Iterative MDU states, 2-bit encoding
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } mdu_state_t;

  // rs1 is treated as signed for MULH, MULHSU, DIV and REM
  function automatic logic f3_signed_a(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

  // rs2 is treated as signed for MULH, DIV and REM
  function automatic logic f3_signed_b(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

endpackage : riscv_pkg
`default_nettype wire

// File: rtl/mdu_div_step.sv
`default_nettype none
// ============================================================================
// Module      : mdu_div_step
// Description : One iteration of a restoring unsigned divider. Shifts the
//               next dividend bit into the partial remainder, trial-subtracts
//               the divisor and keeps the difference when it does not borrow.
// Ports       : rem_in       [XLEN-1:0] partial remainder before this step
//               dividend_msb            next dividend bit (MSB first)
//               divisor      [XLEN-1:0] unsigned divisor
//               rem_out      [XLEN-1:0] partial remainder after this step
//               q_bit                   quotient bit produced by this step
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem_in,
  input  logic            dividend_msb,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_out,
  output logic            q_bit
);

  // The shifted remainder needs XLEN+1 bits: rem_in < divisor, so it is at
  // most 2*divisor-1. After a successful subtract it fits XLEN bits again.
  logic [XLEN:0]   shifted;
  logic [XLEN-1:0] diff;

  always_comb begin
    shifted = {rem_in, dividend_msb};
    q_bit   = (shifted >= {1'b0, divisor});
    diff    = shifted[XLEN-1:0] - divisor;
    rem_out = q_bit ? diff : shifted[XLEN-1:0];
  end

endmodule : mdu_div_step
`default_nettype wire

// File: rtl/mdu_iter.sv
`default_nettype none
// ============================================================================
// Module      : mdu_iter
// Description : Iterative RV32M multiply/divide unit. Radix-2 shift-add
//               multiply and restoring divide, one bit per clock, on operand
//               magnitudes; signs and the RISC-V special cases (divide by
//               zero, signed overflow) are applied in a final FIX cycle.
//               Latency start->done is XLEN+1 edges.
// Ports       : clk, rst         clock / synchronous active-high reset
//               start            request, sampled only while busy=0
//               funct3   [2:0]   RV32M op select
//               op_a, op_b       rs1 / rs2 values
//               rd_in    [4:0]   destination register index
//               busy             operation in progress
//               done             one-cycle result-valid pulse
//               result           result, held until the next done
//               rd_out   [4:0]   destination index, held with result
//               we               reg_file write strobe (done and rd_out!=0)
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_iter
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out,
  output logic            we
);

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [XLEN-1:0] C_MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  mdu_state_t state, state_next;

  logic [CNT_W-1:0]  cnt;
  logic [2:0]        f3_lat;
  logic [4:0]        rd_lat;
  logic [2*XLEN-1:0] prod;      // {partial product, remaining multiplier}
  logic [XLEN-1:0]   mcand;     // |op_b|: multiplicand and divisor
  logic [XLEN-1:0]   quo;       // dividend shifting out, quotient shifting in
  logic [XLEN-1:0]   rem;       // partial remainder
  logic              neg_res;
  logic              div_zero;
  logic              div_ovf;

  // --------------------------------------------------------------------------
  // Accept-time operand conditioning
  // --------------------------------------------------------------------------
  logic            accept;
  logic            a_neg, b_neg;
  logic [XLEN-1:0] abs_a, abs_b;

  always_comb begin
    accept = (state == ST_IDLE) && start;
    a_neg  = f3_signed_a(funct3) && op_a[XLEN-1];
    b_neg  = f3_signed_b(funct3) && op_b[XLEN-1];
    abs_a  = a_neg ? (~op_a + 1'b1) : op_a;
    abs_b  = b_neg ? (~op_b + 1'b1) : op_b;
  end

  // --------------------------------------------------------------------------
  // Iteration datapath: both multiply and divide steps run every CALC cycle;
  // FIX picks whichever the latched op needs.
  // --------------------------------------------------------------------------
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] prod_next;
  logic [XLEN-1:0]   rem_next;
  logic              q_bit;

  always_comb begin
    mul_sum   = {1'b0, prod[2*XLEN-1:XLEN]} + {1'b0, (prod[0] ? mcand : '0)};
    prod_next = {mul_sum, prod[XLEN-1:1]};
  end

  mdu_div_step #(
    .XLEN (XLEN)
  ) u_div_step (
    .rem_in       (rem),
    .dividend_msb (quo[XLEN-1]),
    .divisor      (mcand),
    .rem_out      (rem_next),
    .q_bit        (q_bit)
  );

  // --------------------------------------------------------------------------
  // Result selection into FIX
  // --------------------------------------------------------------------------
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, res_sel;

  always_comb begin
    prod_fix = neg_res ? (~prod + 1'b1) : prod;
    quo_fix  = neg_res ? (~quo  + 1'b1) : quo;
    rem_fix  = neg_res ? (~rem  + 1'b1) : rem;
    res_sel  = '0;
    // Divide by zero leaves the dividend in the remainder (every trial
    // subtract of 0 succeeds), and its sign follows the dividend, so the
    // REM/REMU by-zero result equals op_a without an override.
    case (f3_lat)
      F3_MUL:    res_sel = prod_fix[XLEN-1:0];
      F3_MULH,
      F3_MULHSU,
      F3_MULHU:  res_sel = prod_fix[2*XLEN-1:XLEN];
      F3_DIV:    res_sel = div_zero ? '1 : (div_ovf ? C_MIN_NEG : quo_fix);
      F3_DIVU:   res_sel = div_zero ? '1 : quo_fix;
      F3_REM:    res_sel = div_ovf ? '0 : rem_fix;
      F3_REMU:   res_sel = rem_fix;
      default:   res_sel = '0;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM next state
  // --------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (start) state_next = ST_CALC;
      ST_CALC: if (cnt == '0) state_next = ST_FIX;
      ST_FIX:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM / datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      f3_lat   <= '0;
      rd_lat   <= '0;
      prod     <= '0;
      mcand    <= '0;
      quo      <= '0;
      rem      <= '0;
      neg_res  <= 1'b0;
      div_zero <= 1'b0;
      div_ovf  <= 1'b0;
      done     <= 1'b0;
      we       <= 1'b0;
      result   <= '0;
      rd_out   <= '0;
    end else begin
      state <= state_next;
      done  <= 1'b0;
      we    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            f3_lat   <= funct3;
            rd_lat   <= rd_in;
            prod     <= {{XLEN{1'b0}}, abs_a};
            mcand    <= abs_b;
            quo      <= abs_a;
            rem      <= '0;
            cnt      <= CNT_W'(XLEN - 1);
            // Remainder follows the dividend; everything else is the
            // product of the operand signs.
            neg_res  <= ((funct3 == F3_REM) || (funct3 == F3_REMU)) ? a_neg : (a_neg ^ b_neg);
            div_zero <= (op_b == '0);
            div_ovf  <= f3_signed_b(funct3) && funct3[2] &&
                        (op_a == C_MIN_NEG) && (op_b == '1);
          end
        end
        ST_CALC: begin
          prod <= prod_next;
          rem  <= rem_next;
          quo  <= {quo[XLEN-2:0], q_bit};
          cnt  <= cnt - 1'b1;
        end
        ST_FIX: begin
          result <= res_sel;
          rd_out <= rd_lat;
          done   <= 1'b1;
          we     <= (rd_lat != 5'd0);
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != ST_IDLE);

endmodule : mdu_iter
`default_nettype wire
